// File: rtl/book_mem_arbiter_pkg.sv
// Shared types and constants for the order-book memory arbiter.
package book_mem_arbiter_pkg;

  localparam int unsigned ADDRESS_INDEX = 7;

  localparam int unsigned ADD_REQ    = 0;
  localparam int unsigned CANCEL_REQ = 1;
  localparam int unsigned MATCH_REQ  = 2;

  typedef struct packed {
    logic [15:0] price;
    logic [15:0] quantity;
  } book_entry;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } arb_state_e;

endpackage

// File: rtl/book_arb_pick.sv
// Combinational winner select: first pending requester at or after rr_ptr.
module book_arb_pick #(
  parameter int unsigned N_REQ = 3,
  localparam int unsigned IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [IDW-1:0]   winner,
  output logic             any_pending
);

  int unsigned idx;
  logic [IDW-1:0] sel;

  always_comb begin
    winner      = '0;
    any_pending = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = IDW'(idx);
      if (!any_pending && pending[sel]) begin
        winner      = sel;
        any_pending = 1'b1;
      end
    end
  end

endmodule

// File: rtl/book_mem_arbiter.sv
// Order-book memory port arbiter with request latching and a WAIT watchdog.
// Define BOOK_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module book_mem_arbiter
  import book_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n_in,
  input  logic [N_REQ-1:0]                     req_start,
  input  logic [N_REQ-1:0][ADDRESS_INDEX:0]    req_addr,
  input  logic [N_REQ-1:0]                     req_is_write,
  input  book_entry [N_REQ-1:0]                req_data_w,
  output logic [N_REQ-1:0]                     req_valid,
  output book_entry                            req_data_r,
  output logic [N_REQ-1:0]                     req_pending,
  output logic                                 mem_start,
  output logic [ADDRESS_INDEX:0]               mem_addr,
  output logic                                 mem_is_write,
  output book_entry                            mem_data_w,
  input  logic                                 mem_valid,
  input  book_entry                            mem_data_r,
  output logic [$clog2(N_REQ)-1:0]             grant_id,
  output logic                                 timeout_err,
  output logic                                 drop_err
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);

  arb_state_e                       state_q, state_d;
  logic [N_REQ-1:0]                 pend_q, pend_d, clr;
  logic [N_REQ-1:0][ADDRESS_INDEX:0] slot_addr_q, slot_addr_d;
  logic [N_REQ-1:0]                 slot_wr_q, slot_wr_d;
  book_entry [N_REQ-1:0]            slot_data_q, slot_data_d;
  logic [WDW-1:0]                   wd_q, wd_d;
  logic [N_REQ-1:0]                 req_valid_q, req_valid_d;
  book_entry                        req_data_r_q, req_data_r_d;
  logic                             mem_start_q, mem_start_d;
  logic [ADDRESS_INDEX:0]           mem_addr_q, mem_addr_d;
  logic                             mem_is_write_q, mem_is_write_d;
  book_entry                        mem_data_w_q, mem_data_w_d;
  logic [IDW-1:0]                   grant_id_q, grant_id_d;
  logic                             timeout_err_q, timeout_err_d;
  logic                             drop_err_q, drop_err_d;

  logic [IDW-1:0] rr_ptr, winner;
  logic           any_pending;

  book_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .pending     (pend_q),
    .rr_ptr      (rr_ptr),
    .winner      (winner),
    .any_pending (any_pending)
  );

`ifdef BOOK_ARB_RR_EN
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && any_pending)
      rr_ptr_d = (32'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rr_ptr_q <= '0;
    else           rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  always_comb begin
    state_d        = state_q;
    clr            = '0;
    wd_d           = wd_q;
    req_valid_d    = '0;
    req_data_r_d   = req_data_r_q;
    mem_start_d    = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_is_write_d = mem_is_write_q;
    mem_data_w_d   = mem_data_w_q;
    grant_id_d     = grant_id_q;
    timeout_err_d  = 1'b0;
    drop_err_d     = drop_err_q;
    slot_addr_d    = slot_addr_q;
    slot_wr_d      = slot_wr_q;
    slot_data_d    = slot_data_q;

    case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          mem_addr_d     = slot_addr_q[winner];
          mem_is_write_d = slot_wr_q[winner];
          mem_data_w_d   = slot_data_q[winner];
          mem_start_d    = 1'b1;
          grant_id_d     = winner;
          wd_d           = '0;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_valid) begin
          req_valid_d[grant_id_q] = 1'b1;
          req_data_r_d            = mem_data_r;
          clr[grant_id_q]         = 1'b1;
          state_d                 = ST_IDLE;
        end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          req_valid_d[grant_id_q] = 1'b1;
          timeout_err_d           = 1'b1;
          clr[grant_id_q]         = 1'b1;
          state_d                 = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A start on the completing edge re-arms the slot rather than dropping.
    pend_d = pend_q & ~clr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_start[i]) begin
        if (!pend_q[i] || clr[i]) begin
          pend_d[i]      = 1'b1;
          slot_addr_d[i] = req_addr[i];
          slot_wr_d[i]   = req_is_write[i];
          slot_data_d[i] = req_data_w[i];
        end else begin
          drop_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= ST_IDLE;
      pend_q         <= '0;
      slot_addr_q    <= '0;
      slot_wr_q      <= '0;
      slot_data_q    <= '0;
      wd_q           <= '0;
      req_valid_q    <= '0;
      req_data_r_q   <= '0;
      mem_start_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_is_write_q <= 1'b0;
      mem_data_w_q   <= '0;
      grant_id_q     <= '0;
      timeout_err_q  <= 1'b0;
      drop_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      slot_addr_q    <= slot_addr_d;
      slot_wr_q      <= slot_wr_d;
      slot_data_q    <= slot_data_d;
      wd_q           <= wd_d;
      req_valid_q    <= req_valid_d;
      req_data_r_q   <= req_data_r_d;
      mem_start_q    <= mem_start_d;
      mem_addr_q     <= mem_addr_d;
      mem_is_write_q <= mem_is_write_d;
      mem_data_w_q   <= mem_data_w_d;
      grant_id_q     <= grant_id_d;
      timeout_err_q  <= timeout_err_d;
      drop_err_q     <= drop_err_d;
    end
  end

  assign req_valid    = req_valid_q;
  assign req_data_r   = req_data_r_q;
  assign req_pending  = pend_q;
  assign mem_start    = mem_start_q;
  assign mem_addr     = mem_addr_q;
  assign mem_is_write = mem_is_write_q;
  assign mem_data_w   = mem_data_w_q;
  assign grant_id     = grant_id_q;
  assign timeout_err  = timeout_err_q;
  assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_book_mem_arbiter.sv
// Scoreboard bench for book_mem_arbiter: expected memory commands and
// requester completions are queued by the stimulus and popped by monitors.
module tb_book_mem_arbiter;
  import book_mem_arbiter_pkg::*;

  localparam int unsigned N = 3;

  logic                           clk = 1'b0;
  logic                           rst_n = 1'b0;
  logic [N-1:0]                   req_start = '0;
  logic [N-1:0][ADDRESS_INDEX:0]  req_addr = '0;
  logic [N-1:0]                   req_is_write = '0;
  book_entry [N-1:0]              req_data_w = '0;
  logic [N-1:0]                   req_valid;
  book_entry                      req_data_r;
  logic [N-1:0]                   req_pending;
  logic                           mem_start;
  logic [ADDRESS_INDEX:0]         mem_addr;
  logic                           mem_is_write;
  book_entry                      mem_data_w;
  logic                           mem_valid;
  book_entry                      mem_data_r;
  logic [1:0]                     grant_id;
  logic                           timeout_err;
  logic                           drop_err;

  book_mem_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_start(req_start), .req_addr(req_addr), .req_is_write(req_is_write),
    .req_data_w(req_data_w), .req_valid(req_valid), .req_data_r(req_data_r),
    .req_pending(req_pending), .mem_start(mem_start), .mem_addr(mem_addr),
    .mem_is_write(mem_is_write), .mem_data_w(mem_data_w), .mem_valid(mem_valid),
    .mem_data_r(mem_data_r), .grant_id(grant_id), .timeout_err(timeout_err),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic wr; book_entry data; int gid; } mem_exp_t;
  typedef struct { int id; book_entry data; logic to; } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic book_entry be(input int p, input int q);
    book_entry e;
    e.price = 16'(p);
    e.quantity = 16'(q);
    return e;
  endfunction

  // Memory contents model: price = addr*20+40, quantity = addr+4.
  function automatic book_entry entry_for(input logic [7:0] a);
    return be(int'(a) * 20 + 40, int'(a) + 4);
  endfunction

  task automatic push_mem(input int a, input bit wr, input book_entry d, input int gid);
    mem_exp_t e;
    e.addr = 8'(a); e.wr = wr; e.data = d; e.gid = gid;
    mem_q.push_back(e);
  endtask

  task automatic push_rsp(input int id, input book_entry d, input bit to);
    rsp_exp_t e;
    e.id = id; e.data = d; e.to = to;
    rsp_q.push_back(e);
  endtask

  // Memory command monitor.
  always @(negedge clk) begin
    if (rst_n && mem_start) begin
      if (mem_q.size() == 0) check("unexpected_mem_start", 64'(mem_addr), 64'hFFFF);
      else begin
        mem_exp_t e;
        e = mem_q.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(e.addr));
        check("mem_is_write", 64'(mem_is_write), 64'(e.wr));
        check("mem_data_w", 64'(mem_data_w), 64'(e.data));
        check("grant_id", 64'(grant_id), 64'(e.gid));
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (|req_valid || timeout_err) begin
      check("valid_onehot", 64'($onehot(req_valid)), 64'd1);
      if (rsp_q.size() == 0) check("unexpected_req_valid", 64'({req_valid, timeout_err}), 64'd0);
      else begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        check("req_valid_id", 64'(req_valid), 64'(1) << e.id);
        check("req_data_r", 64'(req_data_r), 64'(e.data));
        check("timeout_err", 64'(timeout_err), 64'(e.to));
      end
    end
  end

  // Memory responder: answers a command so that mem_valid is sampled
  // lat edges after the grant edge; lat == 0 means never answer.
  initial begin
    mem_valid = 1'b0;
    mem_data_r = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_start && lat != 0) begin
        logic [7:0] a;
        int l;
        a = mem_addr;
        l = lat;
        repeat (l - 1) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_data_r = entry_for(a);
        @(posedge clk);
        #1 mem_valid = 1'b0;
      end
    end
  end

  task automatic set_slot(input int id, input int a, input bit wr, input book_entry d);
    req_addr[id] = 8'(a);
    req_is_write[id] = wr;
    req_data_w[id] = d;
  endtask

  task automatic pulse(input logic [N-1:0] mask);
    @(posedge clk); #1 req_start = mask;
    @(posedge clk); #1 req_start = '0;
  endtask

  task automatic issue(input int id, input int a, input bit wr, input book_entry d);
    set_slot(id, a, wr, d);
    pulse(N'(1) << id);
  endtask

  task automatic wait_grant();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_start) seen = 1;
    end
    check("wait_grant_bound", 64'(seen), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_q.size() == 0 && rsp_q.size() == 0 && req_pending == '0 && !mem_start) break;
    end
    @(negedge clk);
    check("drain_mem_q", 64'(mem_q.size()), 64'd0);
    check("drain_rsp_q", 64'(rsp_q.size()), 64'd0);
    check("drain_pending", 64'(req_pending), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    #12;
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_pending", 64'(req_pending), 64'd0);
    check("rst_mem_start", 64'(mem_start), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_drop_err", 64'(drop_err), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_req_data_r", 64'(req_data_r), 64'd0);
    #11 rst_n = 1'b1;

    // Single add: grant one edge after capture, answer 3 edges after grant.
    lat = 3;
    push_mem(5, 1, be(500, 50), ADD_REQ);
    push_rsp(ADD_REQ, be(140, 9), 0);
    issue(ADD_REQ, 5, 1, be(500, 50));
    @(negedge clk);
    check("add_pending_after_capture", 64'(req_pending), 64'b001);
    check("add_no_start_yet", 64'(mem_start), 64'd0);
    @(negedge clk);
    check("add_mem_start_latency", 64'(mem_start), 64'd1);
    drain();

    // Simultaneous starts, memory answers in 2 cycles.
    lat = 2;
    set_slot(ADD_REQ, 10, 1, be(10, 1));
    set_slot(CANCEL_REQ, 11, 0, be(0, 0));
    set_slot(MATCH_REQ, 12, 1, be(12, 3));
`ifdef BOOK_ARB_RR_EN
    push_mem(11, 0, be(0, 0), 1);  push_rsp(1, be(260, 15), 0);
    push_mem(12, 1, be(12, 3), 2); push_rsp(2, be(280, 16), 0);
    push_mem(10, 1, be(10, 1), 0); push_rsp(0, be(240, 14), 0);
`else
    push_mem(10, 1, be(10, 1), 0); push_rsp(0, be(240, 14), 0);
    push_mem(11, 0, be(0, 0), 1);  push_rsp(1, be(260, 15), 0);
    push_mem(12, 1, be(12, 3), 2); push_rsp(2, be(280, 16), 0);
`endif
    pulse(3'b111);
    @(negedge clk);
    check("simul_pending", 64'(req_pending), 64'b111);
    drain();

    // Read return on requester 1.
    push_mem(3, 0, be(0, 0), CANCEL_REQ);
    push_rsp(CANCEL_REQ, be(100, 7), 0);
    issue(CANCEL_REQ, 3, 0, be(0, 0));
    drain();

    // Timeout on requester 2; requester 0 queued behind it.
    lat = 0;
    push_mem(20, 0, be(0, 0), MATCH_REQ);
    push_rsp(MATCH_REQ, be(100, 7), 1);
    push_mem(21, 1, be(21, 21), ADD_REQ);
    push_rsp(ADD_REQ, be(460, 25), 0);
    issue(MATCH_REQ, 20, 0, be(0, 0));
    wait_grant();
    issue(ADD_REQ, 21, 1, be(21, 21));
    lat = 2;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("to_not_before_16", 64'(timeout_err), 64'd0);
    @(negedge clk);
    check("to_pulse_at_16", 64'(timeout_err), 64'd1);
    check("to_pending", 64'(req_pending), 64'b001);
    drain();

    // Drop: second start while pending.
    push_mem(30, 1, be(30, 30), ADD_REQ);
    push_rsp(ADD_REQ, be(640, 34), 0);
    issue(ADD_REQ, 30, 1, be(30, 30));
    issue(ADD_REQ, 31, 1, be(31, 31));
    @(negedge clk);
    check("drop_err_set", 64'(drop_err), 64'd1);
    drain();

    // Set wins: start on the same edge as the completing mem_valid.
    lat = 3;
    push_mem(32, 1, be(32, 32), ADD_REQ);
    push_rsp(ADD_REQ, be(680, 36), 0);
    push_mem(33, 1, be(33, 33), ADD_REQ);
    push_rsp(ADD_REQ, be(700, 37), 0);
    issue(ADD_REQ, 32, 1, be(32, 32));
    wait_grant();
    set_slot(ADD_REQ, 33, 1, be(33, 33));
    @(posedge clk);
    pulse(3'b001);
    @(negedge clk);
    check("setwins_pending", 64'(req_pending), 64'b001);
    check("setwins_valid", 64'(req_valid), 64'b001);
    drain();
    check("drop_err_sticky", 64'(drop_err), 64'd1);

    // Async reset while in WAIT.
    lat = 0;
    push_mem(40, 0, be(0, 0), CANCEL_REQ);
    set_slot(CANCEL_REQ, 40, 0, be(0, 0));
    set_slot(MATCH_REQ, 41, 1, be(41, 41));
    pulse(3'b110);
    wait_grant();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_mem_start", 64'(mem_start), 64'd0);
    check("arst_pending", 64'(req_pending), 64'd0);
    check("arst_req_valid", 64'(req_valid), 64'd0);
    check("arst_mem_addr", 64'(mem_addr), 64'd0);
    check("arst_drop_err", 64'(drop_err), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_pending", 64'(req_pending), 64'd0);
    check("post_rst_mem_q", 64'(mem_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/book_mem_arbiter.md
Name: book_mem_arbiter

Overview:
- Shares the single order-book memory port between N_REQ requesters: add_order = 0, cancel = 1, match/execute = 2.
- Each requester issues a one-cycle start pulse with addr/is_write/data_w, then waits for a one-cycle valid.
- The arbiter latches requests, grants one at a time, drives the memory handshake and returns valid/read data to the winner.
- A watchdog releases the port if memory never answers.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, WAIT cycles without mem_valid before abort (must be >= 2).

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset; asynchronous, active-low.
- req_start  in  N_REQ  per-requester one-cycle request pulse.
- req_addr  in  N_REQ x (ADDRESS_INDEX+1)  per-requester address.
- req_is_write  in  N_REQ  1 = write, 0 = read.
- req_data_w  in  N_REQ x book_entry  write data.
- req_valid  out  N_REQ  one-cycle completion pulse to the granted requester.
- req_data_r  out  book_entry  read data, valid with req_valid.
- req_pending  out  N_REQ  request latched and not yet completed.
- mem_start  out  1  one-cycle memory command pulse.
- mem_addr  out  ADDRESS_INDEX+1  memory address.
- mem_is_write  out  1  memory write enable.
- mem_data_w  out  book_entry  memory write data.
- mem_valid  in  1  memory completion pulse.
- mem_data_r  in  book_entry  memory read data.
- grant_id  out  $clog2(N_REQ)  index of the current or last winner.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- drop_err  out  1  sticky; set when a start pulse is dropped.

Behaviour:
- Reset values (async, on rst_n_in low): state IDLE, all outputs and data/address outputs 0, pending 0, latched request slots 0, watchdog 0, RR pointer 0.
- Request capture:
  - req_start[i] at edge k with pending[i]=0 → slot i latches addr/is_write/data_w and pending[i]=1 after edge k.
  - req_start[i] while pending[i]=1 and not completing that edge → ignored, drop_err set (cleared only by reset).
  - Start and completion for the same i at the same edge → set wins: the new request is latched, pending[i] stays 1.
- FSM states: IDLE, WAIT.
- IDLE:
  - If any pending bit is set, choose winner w by priority (lowest index wins).
  - Drive mem_addr/mem_is_write/mem_data_w from slot w, mem_start=1, grant_id=w, watchdog=0, go to WAIT.
  - Latency: start at edge k → mem_start high after edge k+1.
- WAIT:
  - mem_start=0 after the first WAIT edge; mem outputs hold.
  - mem_valid=1 → req_valid[w]=1 and req_data_r=mem_data_r for one cycle, pending[w] cleared, back to IDLE. The next grant is no earlier than the following edge, so there is always one idle cycle between commands.
  - Otherwise the watchdog increments. When watchdog reaches TIMEOUT_CYCLES-1 without mem_valid: pulse req_valid[w] and timeout_err together, leave req_data_r unchanged, clear pending[w], go to IDLE.
- mem_valid in IDLE is ignored.
- Only one req_valid bit is ever high at a time.
- Reset mid-transaction discards all pending requests; no valid is returned for them.

Optional Feature:
- BOOK_ARB_RR_EN defined: round-robin arbitration.
  - Search starts at (last_grant+1) mod N_REQ.
  - The RR pointer updates on each grant.
- Not defined: fixed priority, index 0 highest; no pointer register.

Decomposition:
- Shared constants package holds book_entry, ADDRESS_INDEX and requester index localparams (ADD_REQ=0, CANCEL_REQ=1, MATCH_REQ=2).
- One sub-module, book_arb_pick: combinational winner select from pending mask plus RR pointer; emits winner index and any_pending.

Test Plan:
- Single add: req_start[0] write, addr 5, at edge 10 → mem_start high after edge 11, mem_addr 5, mem_is_write 1. mem_valid at edge 14 → req_valid[0] high one cycle after edge 14, pending[0] 0.
- Simultaneous: starts on 0, 1, 2 at the same edge, memory answers in 2 cycles.
  - Fixed priority: grant order 0, 1, 2.
  - With BOOK_ARB_RR_EN and last_grant=0: order 1, 2, 0.
- Read return: req 1 read, addr 3; mem_data_r price 100, quantity 7 with mem_valid → req_data_r equals that entry while req_valid[1] is high.
- Timeout: grant requester 2, hold mem_valid 0 → after 16 WAIT cycles timeout_err and req_valid[2] pulse together, FSM IDLE, next pending request granted.
- Drop and set-wins: second req_start[0] while pending → drop_err 1. req_start[0] on the same edge as its mem_valid → pending[0] stays 1 and a new grant follows.
- Async reset in WAIT: rst_n_in low mid-cycle → mem_start, pending, req_valid 0 immediately; no req_valid after release.
